// File: rtl/board_controller_if.sv
// Bus bundle between the game logic / video path and board_controller.
// The master side is the game engine plus pixel scanner; the slave side is
// the board controller that owns the playfield cells.
interface board_controller_if #(
    parameter int unsigned CW = 3
);
    // Video lookup
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic [CW-1:0] pix_color;
    logic          pix_valid;

    // Collision read
    logic [4:0]    rd_row;
    logic [3:0]    rd_col;
    logic [CW-1:0] rd_color;

    // Write handshake
    logic          wr_req;
    logic [4:0]    wr_row;
    logic [3:0]    wr_col;
    logic [CW-1:0] wr_color;
    logic          wr_ack;

    // Board control / line clear
    logic          new_game;
    logic          clear_start;
    logic          busy;
    logic          clear_done;
    logic [4:0]    lines_cleared;

    modport master (
        output DrawX, DrawY, rd_row, rd_col,
        output wr_req, wr_row, wr_col, wr_color,
        output new_game, clear_start,
        input  pix_color, pix_valid, rd_color, wr_ack,
        input  busy, clear_done, lines_cleared
    );

    modport slave (
        input  DrawX, DrawY, rd_row, rd_col,
        input  wr_req, wr_row, wr_col, wr_color,
        input  new_game, clear_start,
        output pix_color, pix_valid, rd_color, wr_ack,
        output busy, clear_done, lines_cleared
    );
endinterface

// File: rtl/board_controller.sv
// Tetris playfield storage: COLS x ROWS cells of CW bits (0 = empty).
// Serves a registered video lookup, a registered collision read, a
// write handshake from the game engine, and an internal line-clear pass
// that scans bottom-up for full rows and collapses the rows above them.
module board_controller #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 22,
    parameter int unsigned CW   = 3,
    parameter int unsigned X0   = 320,
    parameter int unsigned CELL = 20
) (
    input  logic                Clk,
    input  logic                Reset_n,
    board_controller_if.slave   bus
);

    localparam int unsigned X_END = X0 + COLS * CELL;
    localparam int unsigned Y_END = ROWS * CELL;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] board_q [ROWS][COLS];

    logic [4:0]    r_q, r_d;      // scan pointer
    logic [4:0]    d_q, d_d;      // shift destination pointer
    logic [4:0]    lc_q, lc_d;    // lines cleared in current/last pass
    logic          ack_q, ack_d;

    logic [CW-1:0] pix_color_q, pix_color_d;
    logic          pix_valid_q, pix_valid_d;
    logic [CW-1:0] rd_color_q, rd_color_d;

    logic          wipe, do_write, do_shift;
    logic          row_full, wr_in_range;
    logic [9:0]    dx_off, cell_x, cell_y;
    logic          in_field;

    // Video window decode and cell lookup for the pixel under the beam
    always_comb begin
        dx_off      = bus.DrawX - 10'(X0);
        cell_x      = dx_off / 10'(CELL);
        cell_y      = bus.DrawY / 10'(CELL);
        in_field    = (bus.DrawX >= 10'(X0)) && (bus.DrawX < 10'(X_END)) &&
                      (bus.DrawY < 10'(Y_END));
        pix_valid_d = in_field;
        pix_color_d = '0;
        if (in_field) begin
            pix_color_d = board_q[cell_y[4:0]][cell_x[3:0]];
        end
    end

    // Collision read; anything off the board reads as occupied
    always_comb begin
        rd_color_d = '1;
        if ((bus.rd_row < 5'(ROWS)) && (bus.rd_col < 4'(COLS))) begin
            rd_color_d = board_q[bus.rd_row][bus.rd_col];
        end
        wr_in_range = (bus.wr_row < 5'(ROWS)) && (bus.wr_col < 4'(COLS));
    end

    // Full-row detect on the row under the scan pointer
    always_comb begin
        row_full = 1'b1;
        for (int unsigned j = 0; j < COLS; j++) begin
            if (board_q[r_q][j] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // Next-state logic: IDLE arbitration and the scan/shift/done pass
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        d_d      = d_q;
        lc_d     = lc_q;
        ack_d    = 1'b0;
        wipe     = 1'b0;
        do_write = 1'b0;
        do_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.new_game) begin
                    wipe = 1'b1;
                end else if (bus.clear_start) begin
                    lc_d    = '0;
                    r_d     = 5'(ROWS - 1);
                    state_d = SCAN;
                end else if (bus.wr_req && !ack_q) begin
                    // Acked even when the address is off-board; the data is dropped
                    ack_d    = 1'b1;
                    do_write = wr_in_range;
                end
            end
            SCAN: begin
                if (row_full) begin
                    lc_d    = (lc_q == 5'd31) ? lc_q : lc_q + 5'd1;
                    d_d     = r_q;
                    state_d = SHIFT;
                end else if (r_q == '0) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q - 5'd1;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                // r stays put so the row that dropped into it is rescanned
                if (d_q == '0) begin
                    state_d = SCAN;
                end else begin
                    d_d = d_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            lc_q        <= '0;
            ack_q       <= 1'b0;
            pix_color_q <= '0;
            pix_valid_q <= 1'b0;
            rd_color_q  <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            d_q         <= d_d;
            lc_q        <= lc_d;
            ack_q       <= ack_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= pix_valid_d;
            rd_color_q  <= rd_color_d;
        end
    end

    // Cell storage: wipe, engine write, or one row of the collapse per cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    board_q[i][j] <= '0;
                end
            end
        end else if (wipe) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    board_q[i][j] <= '0;
                end
            end
        end else if (do_write) begin
            board_q[bus.wr_row][bus.wr_col] <= bus.wr_color;
        end else if (do_shift) begin
            if (d_q == '0) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    board_q[0][j] <= '0;
                end
            end
            for (int unsigned i = 1; i < ROWS; i++) begin
                if (d_q == 5'(i)) begin
                    for (int unsigned j = 0; j < COLS; j++) begin
                        board_q[i][j] <= board_q[i-1][j];
                    end
                end
            end
        end
    end

    assign bus.pix_color     = pix_color_q;
    assign bus.pix_valid     = pix_valid_q;
    assign bus.rd_color      = rd_color_q;
    assign bus.wr_ack        = ack_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.clear_done    = (state_q == DONE);
    assign bus.lines_cleared = lc_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: video lookup, collision read,
// write handshake and the line-clear pass, with hand-computed expectations.
module tb_board_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    board_controller_if #(.CW(3)) bus ();

    board_controller #(
        .COLS (10),
        .ROWS (22),
        .CW   (3),
        .X0   (320),
        .CELL (20)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input logic [4:0] r, input logic [3:0] c, input logic [2:0] v);
        int n;
        bus.wr_row   = r;
        bus.wr_col   = c;
        bus.wr_color = v;
        bus.wr_req   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.wr_ack && n < 60);
        bus.wr_req = 1'b0;
        if (!bus.wr_ack) begin
            total++;
            bad++;
            $display("FAIL write_timeout row=%0d col=%0d got no ack, required ack", r, c);
        end
        tick();
    endtask

    task automatic read_cell(input logic [4:0] r, input logic [3:0] c, output logic [2:0] v);
        bus.rd_row = r;
        bus.rd_col = c;
        tick();
        v = bus.rd_color;
    endtask

    // Called right after the edge that sampled clear_start; cyc=1 is the first busy cycle.
    task automatic wait_done(output int cyc, output bit busy_ok);
        busy_ok = 1'b1;
        cyc = -1;
        for (int n = 1; n <= 300; n++) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.clear_done) begin
                cyc = n;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
    endtask

    task automatic start_clear();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
    endtask

    task automatic test_reset();
        if (bus.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%0b exp=0", bus.pix_valid); end
        total++;
        if (bus.pix_color !== 3'd0) begin bad++; $display("FAIL rst_pix_color got=%0d exp=0", bus.pix_color); end
        total++;
        if (bus.rd_color !== 3'd0) begin bad++; $display("FAIL rst_rd_color got=%0d exp=0", bus.rd_color); end
        total++;
        if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL rst_wr_ack got=%0b exp=0", bus.wr_ack); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        total++;
        if (bus.clear_done !== 1'b0) begin bad++; $display("FAIL rst_clear_done got=%0b exp=0", bus.clear_done); end
        total++;
        if (bus.lines_cleared !== 5'd0) begin bad++; $display("FAIL rst_lines got=%0d exp=0", bus.lines_cleared); end
        total++;
    endtask

    task automatic test_write_read();
        bus.wr_row = 5'd3; bus.wr_col = 4'd4; bus.wr_color = 3'd5; bus.wr_req = 1'b1;
        tick();
        total++;
        if (bus.wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack_latency got=%0b exp=1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        bus.rd_row = 5'd3; bus.rd_col = 4'd4;
        tick();
        total++;
        if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_single got=%0b exp=0", bus.wr_ack); end
        total++;
        if (bus.rd_color !== 3'd5) begin bad++; $display("FAIL rd_3_4 got=%0d exp=5", bus.rd_color); end
        bus.DrawX = 10'd400; bus.DrawY = 10'd70;
        tick();
        total++;
        if (bus.pix_valid !== 1'b1 || bus.pix_color !== 3'd5) begin
            bad++; $display("FAIL pix_400_70 got=%0b/%0d exp=1/5", bus.pix_valid, bus.pix_color);
        end
        bus.rd_row = 5'd22; bus.rd_col = 4'd0;
        tick();
        total++;
        if (bus.rd_color !== 3'd7) begin bad++; $display("FAIL rd_row_oob got=%0d exp=7", bus.rd_color); end
        bus.rd_row = 5'd0; bus.rd_col = 4'd10;
        tick();
        total++;
        if (bus.rd_color !== 3'd7) begin bad++; $display("FAIL rd_col_oob got=%0d exp=7", bus.rd_color); end
        bus.wr_row = 5'd25; bus.wr_col = 4'd0; bus.wr_color = 3'd1; bus.wr_req = 1'b1;
        tick();
        total++;
        if (bus.wr_ack !== 1'b1) begin bad++; $display("FAIL wr_oob_ack got=%0b exp=1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        tick();
    endtask

    task automatic test_video_bounds();
        logic [9:0] xs [7];
        logic [9:0] ys [7];
        logic       ev [7];
        logic [2:0] ec [7];
        xs = '{10'd319, 10'd520, 10'd400, 10'd339, 10'd419, 10'd420, 10'd519};
        ys = '{10'd70,  10'd70,  10'd440, 10'd439, 10'd79,  10'd70,  10'd60};
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ec = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
        for (int i = 0; i < 7; i++) begin
            bus.DrawX = xs[i];
            bus.DrawY = ys[i];
            tick();
            total++;
            if (bus.pix_valid !== ev[i] || bus.pix_color !== ec[i]) begin
                bad++;
                $display("FAIL pix_window x=%0d y=%0d got=%0b/%0d exp=%0b/%0d",
                         xs[i], ys[i], bus.pix_valid, bus.pix_color, ev[i], ec[i]);
            end
        end
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    endtask

    task automatic test_new_game();
        logic [2:0] v;
        pulse_new_game();
        read_cell(5'd3, 4'd4, v);
        total++;
        if (v !== 3'd0) begin bad++; $display("FAIL new_game_wipe got=%0d exp=0", v); end
    endtask

    task automatic test_empty_clear();
        int cyc;
        bit ok;
        start_clear();
        wait_done(cyc, ok);
        total++;
        if (cyc != 23) begin bad++; $display("FAIL empty_done_cycle got=%0d exp=23", cyc); end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL empty_busy got=drop exp=held"); end
        total++;
        if (bus.lines_cleared !== 5'd0) begin bad++; $display("FAIL empty_lines got=%0d exp=0", bus.lines_cleared); end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            bad++; $display("FAIL empty_after got=%0b/%0b exp=0/0", bus.busy, bus.clear_done);
        end
    endtask

    task automatic test_one_row();
        int cyc;
        bit ok;
        logic [2:0] v;
        int errs;
        for (int c = 0; c < 10; c++) write_cell(5'd21, 4'(c), 3'd2);
        write_cell(5'd20, 4'd0, 3'd6);
        start_clear();
        wait_done(cyc, ok);
        total++;
        if (cyc != 46) begin bad++; $display("FAIL one_done_cycle got=%0d exp=46", cyc); end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL one_busy got=drop exp=held"); end
        total++;
        if (bus.lines_cleared !== 5'd1) begin bad++; $display("FAIL one_lines got=%0d exp=1", bus.lines_cleared); end
        read_cell(5'd21, 4'd0, v);
        total++;
        if (v !== 3'd6) begin bad++; $display("FAIL one_drop got=%0d exp=6", v); end
        errs = 0;
        for (int r = 0; r < 22; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (r == 21 && c == 0) continue;
                read_cell(5'(r), 4'(c), v);
                total++;
                if (v !== 3'd0) begin
                    bad++; errs++;
                    if (errs < 5) $display("FAIL one_empty r=%0d c=%0d got=%0d exp=0", r, c, v);
                end
            end
        end
        total++;
        if (bus.lines_cleared !== 5'd1) begin bad++; $display("FAIL one_lines_hold got=%0d exp=1", bus.lines_cleared); end
    endtask

    task automatic test_two_rows();
        int cyc;
        bit ok;
        logic [2:0] v;
        int errs;
        pulse_new_game();
        for (int c = 0; c < 10; c++) write_cell(5'd21, 4'(c), 3'((c % 7) + 1));
        for (int c = 0; c < 10; c++) write_cell(5'd20, 4'(c), 3'd3);
        start_clear();
        wait_done(cyc, ok);
        total++;
        if (cyc != 69) begin bad++; $display("FAIL two_done_cycle got=%0d exp=69", cyc); end
        total++;
        if (bus.lines_cleared !== 5'd2) begin bad++; $display("FAIL two_lines got=%0d exp=2", bus.lines_cleared); end
        errs = 0;
        for (int r = 0; r < 22; r++) begin
            for (int c = 0; c < 10; c++) begin
                read_cell(5'(r), 4'(c), v);
                total++;
                if (v !== 3'd0) begin
                    bad++; errs++;
                    if (errs < 5) $display("FAIL two_empty r=%0d c=%0d got=%0d exp=0", r, c, v);
                end
            end
        end
    endtask

    task automatic test_write_vs_clear();
        int done_cyc;
        int ack_cyc;
        bit early;
        logic [2:0] v;
        pulse_new_game();
        bus.wr_row = 5'd5; bus.wr_col = 4'd5; bus.wr_color = 3'd3; bus.wr_req = 1'b1;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        done_cyc = -1; ack_cyc = -1; early = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (bus.clear_done) done_cyc = cyc;
            if (bus.wr_ack) begin
                if (done_cyc < 0 || bus.busy) early = 1'b1;
                ack_cyc = cyc;
                break;
            end
            tick();
        end
        bus.wr_req = 1'b0;
        total++;
        if (done_cyc != 23) begin bad++; $display("FAIL wvc_done_cycle got=%0d exp=23", done_cyc); end
        total++;
        if (ack_cyc != 25) begin bad++; $display("FAIL wvc_ack_cycle got=%0d exp=25", ack_cyc); end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL wvc_ack_while_busy got=1 exp=0"); end
        tick();
        total++;
        if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL wvc_second_ack got=%0b exp=0", bus.wr_ack); end
        read_cell(5'd5, 4'd5, v);
        total++;
        if (v !== 3'd3) begin bad++; $display("FAIL wvc_cell got=%0d exp=3", v); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] v;
        bus.wr_row = 5'd6; bus.wr_col = 4'd1; bus.wr_color = 3'd4; bus.wr_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++;
            if (bus.wr_ack !== 1'((i % 2) == 1)) begin
                bad++; $display("FAIL b2b_ack cycle=%0d got=%0b exp=%0b", i, bus.wr_ack, (i % 2) == 1);
            end
        end
        bus.wr_req = 1'b0;
        tick();
        read_cell(5'd6, 4'd1, v);
        total++;
        if (v !== 3'd4) begin bad++; $display("FAIL b2b_cell got=%0d exp=4", v); end
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        logic [2:0] v;
        pulse_new_game();
        for (int c = 0; c < 10; c++) write_cell(5'd21, 4'(c), 3'd1);
        start_clear();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bus.busy !== 1'b1 || bus.lines_cleared !== 5'd1) begin
            bad++; $display("FAIL mid_shift_pre got=%0b/%0d exp=1/1", bus.busy, bus.lines_cleared);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.lines_cleared !== 5'd0) begin
            bad++; $display("FAIL mid_shift_rst got=%0b/%0b/%0d exp=0/0/0",
                            bus.busy, bus.clear_done, bus.lines_cleared);
        end
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.clear_done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid_shift_done got=1 exp=0"); end
        read_cell(5'd21, 4'd0, v);
        total++;
        if (v !== 3'd0) begin bad++; $display("FAIL mid_shift_r21c0 got=%0d exp=0", v); end
        read_cell(5'd20, 4'd9, v);
        total++;
        if (v !== 3'd0) begin bad++; $display("FAIL mid_shift_r20c9 got=%0d exp=0", v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.DrawX = '0; bus.DrawY = '0;
        bus.rd_row = '0; bus.rd_col = '0;
        bus.wr_req = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_color = '0;
        bus.new_game = 1'b0; bus.clear_start = 1'b0;
        #12;
        test_reset();
        #10 rst_n = 1'b1;
        tick();
        test_write_read();
        test_video_bounds();
        test_new_game();
        test_empty_clear();
        test_one_row();
        test_two_rows();
        test_write_vs_clear();
        test_back_to_back();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_controller.md
Name: board_controller

Overview:
- Owns the Tetris playfield cell storage: COLS x ROWS cells, CW bits each. A cell value of 0 means empty.
- Serves three clients:
  - the VGA pixel path, as a read-only cell lookup inside the playfield window;
  - the game engine, as a write handshake plus a registered collision read;
  - the line-clear engine, an internal FSM that scans for full rows and collapses them.
- Sits between game logic and the colour mapper. It runs alongside grid_mapper, which draws the cell outlines over the same window.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 22, playfield height in cells.
- CW, 3, colour code bits per cell.
- X0, 320, first pixel column of the playfield.
- CELL, 20, cell edge length in pixels.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- pix_color  out  CW  cell colour at the pixel, registered.
- pix_valid  out  1  pixel lies inside the playfield window, registered.
- rd_row  in  5  collision read row.
- rd_col  in  4  collision read column.
- rd_color  out  CW  cell at (rd_row, rd_col), registered.
- wr_req  in  1  write request; held high until wr_ack.
- wr_row  in  5  write row.
- wr_col  in  4  write column.
- wr_color  in  CW  write data.
- wr_ack  out  1  one-cycle pulse; the write has been committed.
- new_game  in  1  pulse; wipe the board.
- clear_start  in  1  pulse; begin the line-clear pass.
- busy  out  1  FSM is not in IDLE.
- clear_done  out  1  one-cycle pulse at the end of the pass.
- lines_cleared  out  5  number of rows removed in the last pass; holds until the next pass.

Behaviour:
- Reset (async, Reset_n=0):
  - All cells become 0 and the FSM goes to IDLE.
  - All outputs become 0.
- Video path:
  - in_field = (X0 <= DrawX < X0+COLS*CELL) and (DrawY < ROWS*CELL).
  - col = (DrawX-X0)/CELL and row = DrawY/CELL, integer division.
  - Next cycle: pix_valid = in_field, and pix_color = board[row][col] if in_field, else 0. Latency is 1 clock.
  - Never stalled. During a SHIFT the video may show intermediate contents; one-frame tearing is accepted.
- Collision read:
  - rd_color = board[rd_row][rd_col], registered, 1-clock latency. Available in every state.
  - An out-of-range row or column returns all-ones (reads as occupied).
- FSM states and transitions:
  - IDLE:
    - new_game has highest priority: all cells go to 0 in one cycle.
    - clear_start comes next: lines_cleared goes to 0, the scan pointer r goes to ROWS-1, and the FSM goes to SCAN.
    - wr_req comes last. If wr_row and wr_col are in range, the cell is written on this edge. wr_ack pulses the next cycle whether or not the address was in range; an out-of-range write is dropped but still acknowledged.
    - wr_ack is never issued on consecutive cycles. A requester that keeps wr_req high gets one write every two cycles.
  - SCAN:
    - If every cell in row r is non-zero: lines_cleared increments (saturating at 31), the destination pointer d goes to r, and the FSM goes to SHIFT.
    - Otherwise, if r == 0, the FSM goes to DONE.
    - Otherwise r decrements and the FSM stays in SCAN.
  - SHIFT:
    - Each cycle, board[d] = board[d-1] when d > 0, else board[d] = 0.
    - When d == 0, the FSM returns to SCAN with r unchanged, so the row that dropped into r is rescanned. Otherwise d decrements.
    - A shift therefore takes r+1 cycles.
  - DONE: clear_done pulses for 1 cycle, then the FSM goes to IDLE.
- busy = (state != IDLE).
- Inputs ignored while busy:
  - clear_start and new_game are ignored.
  - wr_req is stalled with no ack until IDLE, and the requester keeps its inputs stable.
- Reset mid-pass wipes the board and returns the FSM to IDLE; no clear_done is issued.

Test Plan:
- Reset, then write (3,4)=5 -> wr_ack 1 cycle after the request. Next, with rd_row=3, rd_col=4: rd_color=5 one clock after the read address is applied. With DrawX=400, DrawY=70: pix_valid=1 and pix_color=5 one clock later.
- Empty board, clear_start at cycle k:
  - busy is high from k+1 to k+23.
  - clear_done at k+23.
  - lines_cleared=0.
- Row 21 full (all cells = 2) and row 20 holding one cell (20,0)=6; clear_start at k:
  - clear_done at k+46, lines_cleared=1.
  - Afterwards (21,0)=6 and rows 0-20 are all 0.
- Rows 21 and 20 both full, rows 19-0 empty; clear_start at k:
  - lines_cleared=2.
  - Whole board is 0 at DONE.
  - clear_done at k+69.
- Edge cases:
  - wr_req held during a pass -> no wr_ack until IDLE, then exactly one ack.
  - clear_start and wr_req in the same IDLE cycle -> the pass starts first and the write commits after DONE.
  - DrawX=319 or 520, or DrawY=440 -> pix_valid=0 and pix_color=0.
- Reset_n low mid-SHIFT -> board cleared immediately, busy=0, no clear_done pulse.
